// File: rtl/spi_master_arbiter_if.sv
// Bus between the two-requester SPI master arbiter, its requesters and the SPI slaves.
// The master modport is the arbiter side; the slave modport is the requester/slave side.
interface spi_master_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic       cpha;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       cs0;
    logic       cs1;
    logic       mosi;
    logic       miso;

    modport master (
        input  req0, req1, tx0, tx1, cpha, miso,
        output gnt0, gnt1, done0, done1, rx_data, busy, sclk, cs0, cs1, mosi
    );

    modport slave (
        output req0, req1, tx0, tx1, cpha, miso,
        input  gnt0, gnt1, done0, done1, rx_data, busy, sclk, cs0, cs1, mosi
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter in front of a single-byte SPI master (CPOL=0, selectable CPHA).
// Each granted frame runs SETUP, 16 sclk half-periods, HOLD and an inter-frame GAP.
module spi_master_arbiter #(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_master_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] LastCnt = 8'(CLK_DIV - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_cnt;
    logic [3:0] r_half;
    logic       r_owner;
    logic       r_last;
    logic       r_cpha;
    logic [7:0] r_txByte;
    logic [7:0] r_rxShift;
    logic [7:0] r_rxData;
    logic       r_sclk;
    logic       r_mosi;

    logic       w_periodEnd;
    logic       w_grant;
    logic       w_pick;
    logic [7:0] w_txSel;
    logic       w_edge;
    logic [4:0] w_edgeNum;
    logic       w_sample;
    logic       w_drive;
    logic [2:0] w_bitIdx;
    logic       w_active;

    // Edge n of sclk is launched by the clk edge that starts half-period n.
    always_comb begin
        w_periodEnd = (r_cnt == LastCnt);
        w_grant     = reset && (r_state == IDLE) && (bus.req0 || bus.req1);
        w_pick      = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
        w_txSel     = w_pick ? bus.tx1 : bus.tx0;
        w_edge      = w_periodEnd && ((r_state == SETUP) ||
                                      ((r_state == XFER) && (r_half != 4'd15)));
        w_edgeNum   = (r_state == SETUP) ? 5'd1 : ({1'b0, r_half} + 5'd2);
        w_sample    = w_edge && (r_cpha ? ~w_edgeNum[0] : w_edgeNum[0]);
        w_drive     = w_edge && (r_cpha ? w_edgeNum[0]
                                        : (~w_edgeNum[0] && (w_edgeNum != 5'd16)));
        w_bitIdx    = 3'd7 - w_edgeNum[3:1];
        w_active    = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_nextState = SETUP;
            SETUP:   if (w_periodEnd) w_nextState = XFER;
            XFER:    if (w_periodEnd && (r_half == 4'd15)) w_nextState = HOLD;
            HOLD:    if (w_periodEnd) w_nextState = GAP;
            GAP:     if (w_periodEnd) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= 8'd0;
            r_half    <= 4'd0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_cpha    <= 1'b0;
            r_txByte  <= 8'h00;
            r_rxShift <= 8'h00;
            r_rxData  <= 8'h00;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            if ((r_state == IDLE) || w_periodEnd) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_grant) begin
                r_owner  <= w_pick;
                r_last   <= w_pick;
                r_cpha   <= bus.cpha;
                r_txByte <= w_txSel;
                r_half   <= 4'd0;
                r_mosi   <= ~bus.cpha & w_txSel[7];
            end
            if ((r_state == XFER) && w_periodEnd) begin
                r_half <= r_half + 4'd1;
            end
            if (w_edge) begin
                r_sclk <= ~r_sclk;
            end
            if (w_sample) begin
                r_rxShift <= {r_rxShift[6:0], bus.miso};
            end
            if (w_drive) begin
                r_mosi <= r_txByte[w_bitIdx];
            end
            // Leaving HOLD publishes the byte and parks mosi for the GAP.
            if ((r_state == HOLD) && w_periodEnd) begin
                r_rxData <= r_rxShift;
                r_mosi   <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.gnt0    = w_grant && ~w_pick;
        bus.gnt1    = w_grant && w_pick;
        bus.done0   = (r_state == GAP) && (r_cnt == 8'd0) && ~r_owner;
        bus.done1   = (r_state == GAP) && (r_cnt == 8'd0) && r_owner;
        bus.busy    = (r_state != IDLE);
        bus.cs0     = ~(w_active && ~r_owner);
        bus.cs1     = ~(w_active && r_owner);
        bus.sclk    = r_sclk;
        bus.mosi    = r_mosi;
        bus.rx_data = r_rxData;
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: instances with CLK_DIV=2 and CLK_DIV=1,
// a behavioural SPI slave, and a round-robin reference model.
module tb_spi_master_arbiter;
    typedef struct {
        int         gntCycle;
        int         doneCycle;
        int         who;
        int         bothGnt;
        int         csFirst;
        int         csLast;
        int         csLowCount;
        int         rises;
        int         otherCs;
        int         otherDone;
        int         badMosi;
        int         timeout;
        logic [7:0] rx;
        logic [7:0] slaveGot;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       req0, req1, cpha, miso;
    logic [7:0] tx0, tx1;
    bit         useOne;
    bit         rrLast;
    int         clkDiv;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    logic       gnt0, gnt1, done0, done1, busy, sclk, cs0, cs1, mosi;
    logic [7:0] rxData;

    spi_master_arbiter_if bus2();
    spi_master_arbiter_if bus1();

    assign bus2.req0 = req0 & ~useOne;
    assign bus2.req1 = req1 & ~useOne;
    assign bus2.tx0  = tx0;
    assign bus2.tx1  = tx1;
    assign bus2.cpha = cpha;
    assign bus2.miso = miso;
    assign bus1.req0 = req0 & useOne;
    assign bus1.req1 = req1 & useOne;
    assign bus1.tx0  = tx0;
    assign bus1.tx1  = tx1;
    assign bus1.cpha = cpha;
    assign bus1.miso = miso;

    assign gnt0   = useOne ? bus1.gnt0    : bus2.gnt0;
    assign gnt1   = useOne ? bus1.gnt1    : bus2.gnt1;
    assign done0  = useOne ? bus1.done0   : bus2.done0;
    assign done1  = useOne ? bus1.done1   : bus2.done1;
    assign busy   = useOne ? bus1.busy    : bus2.busy;
    assign sclk   = useOne ? bus1.sclk    : bus2.sclk;
    assign cs0    = useOne ? bus1.cs0     : bus2.cs0;
    assign cs1    = useOne ? bus1.cs1     : bus2.cs1;
    assign mosi   = useOne ? bus1.mosi    : bus2.mosi;
    assign rxData = useOne ? bus1.rx_data : bus2.rx_data;

    spi_master_arbiter #(.CLK_DIV(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));
    spi_master_arbiter #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Round-robin reference: a tie goes to the requester not served last.
    function automatic int modelPick(input bit r0, input bit r1);
        int w;
        w = (r0 && r1) ? (rrLast ? 0 : 1) : (r1 ? 1 : 0);
        rrLast = (w == 1);
        return w;
    endfunction

    task automatic do_reset;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        rrLast = 1'b1;
    endtask

    // Raises requests, waits for a grant, then plays SPI slave until the owner's done.
    task automatic applyStimulus(input logic [1:0] raise, input logic [1:0] keep,
                                 input logic [7:0] t0v, input logic [7:0] t1v,
                                 input logic ph, input logic [7:0] sb, input bit loop,
                                 output obs_t o);
        bit got, fin;
        int k;
        logic sclkPrev, csPrev, mosiPrev, csOwn, csOther, dn, dnOther;
        logic [7:0] sIn;
        o.gntCycle = -1; o.doneCycle = -1; o.who = -1; o.bothGnt = 0;
        o.csFirst = 0; o.csLast = 0; o.csLowCount = 0; o.rises = 0;
        o.otherCs = 0; o.otherDone = 0; o.badMosi = 0; o.timeout = 0;
        o.rx = 8'h00; o.slaveGot = 8'h00;
        if (raise[0]) req0 = 1'b1;
        if (raise[1]) req1 = 1'b1;
        tx0 = t0v; tx1 = t1v; cpha = ph;
        got = 0;
        for (int i = 0; i < 40 * clkDiv + 20 && !got; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = 1; o.gntCycle = cyc; o.who = gnt1 ? 1 : 0; o.bothGnt = int'(gnt0 && gnt1);
            end
            @(posedge clk); #1;
        end
        if (!got) begin o.timeout = 1; return; end
        if (o.who == 0 && !keep[0]) req0 = 1'b0;
        if (o.who == 1 && !keep[1]) req1 = 1'b0;
        if (o.who == 0) tx0 = 8'($urandom); else tx1 = 8'($urandom);
        cpha = 1'($urandom);
        sclkPrev = 1'b0; csPrev = 1'b1; mosiPrev = mosi; k = 7; sIn = 8'h00; fin = 0;
        for (int i = 0; i < 25 * clkDiv + 10 && !fin; i++) begin
            @(negedge clk);
            csOwn   = (o.who == 1) ? cs1 : cs0;
            csOther = (o.who == 1) ? cs0 : cs1;
            dn      = (o.who == 1) ? done1 : done0;
            dnOther = (o.who == 1) ? done0 : done1;
            if (!csOther) o.otherCs = 1;
            if (dnOther) o.otherDone = 1;
            if (!csOwn) begin
                if (o.csFirst == 0) o.csFirst = cyc;
                o.csLast = cyc;
                o.csLowCount++;
            end
            if (!csOwn && !csPrev && (mosi !== mosiPrev)) begin
                if (ph ? !(sclk && !sclkPrev) : !(!sclk && sclkPrev)) o.badMosi++;
            end
            if (sclk && !sclkPrev) begin
                o.rises++;
                if (!ph) sIn = {sIn[6:0], mosi};
                else if (k >= 0) begin miso = sb[k]; k--; end
            end
            if (!sclk && sclkPrev) begin
                if (ph) sIn = {sIn[6:0], mosi};
                else if (k >= 0) begin miso = sb[k]; k--; end
            end
            if (!ph && !csOwn && csPrev) begin miso = sb[7]; k = 6; end
            if (loop) miso = mosi;
            if (dn) begin fin = 1; o.doneCycle = cyc; o.rx = rxData; end
            sclkPrev = sclk; csPrev = csOwn; mosiPrev = mosi;
            @(posedge clk); #1;
        end
        if (!fin) o.timeout = 1;
        o.slaveGot = sIn;
    endtask

    task automatic test_reset;
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b%b expected 00", gnt1, gnt0); end
        checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b%b expected 00", done1, done0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk_mosi: got %b/%b expected 0/0", sclk, mosi); end
        checks++; if (cs0 !== 1'b1 || cs1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs: got %b%b expected 11", cs1, cs0); end
        checks++; if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx: got %h expected 00", rxData); end
        checks++; if (bus1.busy !== 1'b0 || bus1.cs0 !== 1'b1 || bus1.cs1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_div1: got busy=%b cs=%b%b expected 0 11", bus1.busy, bus1.cs1, bus1.cs0); end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0; reset = 1'b1; rrLast = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_loopback_cpha0;
        obs_t o;
        int expWho;
        expWho = modelPick(1'b1, 1'b0);
        applyStimulus(2'b01, 2'b00, 8'hAD, 8'h55, 1'b0, 8'h00, 1'b1, o);
        checks++; if (o.timeout != 0) begin errors++; $display("[TB] FAIL lb_timeout: got %0d expected 0", o.timeout); end
        checks++; if (o.who != expWho) begin errors++; $display("[TB] FAIL lb_owner: got %0d expected %0d", o.who, expWho); end
        checks++; if (o.doneCycle - o.gntCycle != 1 + 18 * clkDiv) begin errors++; $display("[TB] FAIL lb_latency: got %0d expected %0d", o.doneCycle - o.gntCycle, 1 + 18 * clkDiv); end
        checks++; if (o.csFirst != o.gntCycle + 1 || o.csLast != o.gntCycle + 18 * clkDiv) begin errors++; $display("[TB] FAIL lb_cs_window: got %0d..%0d expected %0d..%0d", o.csFirst - o.gntCycle, o.csLast - o.gntCycle, 1, 18 * clkDiv); end
        checks++; if (o.rises != 8) begin errors++; $display("[TB] FAIL lb_rises: got %0d expected 8", o.rises); end
        checks++; if (o.rx !== 8'hAD) begin errors++; $display("[TB] FAIL lb_rx: got %h expected ad", o.rx); end
        checks++; if (o.otherCs != 0 || o.otherDone != 0) begin errors++; $display("[TB] FAIL lb_other: got cs=%0d done=%0d expected 0 0", o.otherCs, o.otherDone); end
        checks++; if (o.badMosi != 0) begin errors++; $display("[TB] FAIL lb_mosi_edge: got %0d expected 0", o.badMosi); end
    endtask

    task automatic test_cpha1_slave;
        obs_t o;
        int expWho;
        expWho = modelPick(1'b0, 1'b1);
        applyStimulus(2'b10, 2'b00, 8'h12, 8'h69, 1'b1, 8'h3C, 1'b0, o);
        checks++; if (o.who != expWho || o.timeout != 0) begin errors++; $display("[TB] FAIL c1_owner: got %0d timeout=%0d expected %0d", o.who, o.timeout, expWho); end
        checks++; if (o.rx !== 8'h3C) begin errors++; $display("[TB] FAIL c1_rx: got %h expected 3c", o.rx); end
        checks++; if (o.slaveGot !== 8'h69) begin errors++; $display("[TB] FAIL c1_slave_rx: got %h expected 69", o.slaveGot); end
        checks++; if (o.badMosi != 0) begin errors++; $display("[TB] FAIL c1_mosi_edge: got %0d expected 0", o.badMosi); end
        checks++; if (o.otherCs != 0) begin errors++; $display("[TB] FAIL c1_cs0: got %0d expected 0", o.otherCs); end
        checks++; if (o.doneCycle - o.gntCycle != 1 + 18 * clkDiv) begin errors++; $display("[TB] FAIL c1_latency: got %0d expected %0d", o.doneCycle - o.gntCycle, 1 + 18 * clkDiv); end
    endtask

    task automatic test_arbitration;
        obs_t o;
        int expWho, prevDone;
        logic [7:0] a, b, expTx;
        do_reset();
        prevDone = -1;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            expWho = modelPick(1'b1, 1'b1);
            expTx = (expWho == 1) ? b : a;
            applyStimulus(2'b11, 2'b11, a, b, 1'b0, 8'h00, 1'b1, o);
            checks++; if (o.who != expWho || o.bothGnt != 0) begin errors++; $display("[TB] FAIL arb_order%0d: got %0d both=%0d expected %0d", i, o.who, o.bothGnt, expWho); end
            checks++; if (o.rx !== expTx) begin errors++; $display("[TB] FAIL arb_rx%0d: got %h expected %h", i, o.rx, expTx); end
            if (i > 0) begin
                checks++; if (o.gntCycle - prevDone != clkDiv) begin errors++; $display("[TB] FAIL arb_gap%0d: got %0d expected %0d", i, o.gntCycle - prevDone, clkDiv); end
            end
            prevDone = o.doneCycle;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        int expWho, prevDone;
        logic [7:0] a;
        prevDone = -1;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            expWho = modelPick(1'b1, 1'b0);
            applyStimulus(2'b01, 2'b01, a, 8'h00, 1'b0, 8'h00, 1'b1, o);
            checks++; if (o.who != expWho || o.rx !== a) begin errors++; $display("[TB] FAIL b2b_frame%0d: got owner %0d rx %h expected %0d %h", i, o.who, o.rx, expWho, a); end
            if (i > 0) begin
                checks++; if (o.gntCycle - prevDone != clkDiv) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %0d expected %0d", i, o.gntCycle - prevDone, clkDiv); end
            end
            prevDone = o.doneCycle;
        end
        req0 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_random;
        obs_t o;
        int who, expWho;
        logic [7:0] a, b, sb, expTx;
        logic ph;
        for (int i = 0; i < 8; i++) begin
            who = int'($urandom_range(1, 0));
            a = 8'($urandom); b = 8'($urandom); sb = 8'($urandom); ph = 1'($urandom);
            expWho = modelPick(who == 0, who == 1);
            expTx = (expWho == 1) ? b : a;
            applyStimulus((who == 1) ? 2'b10 : 2'b01, 2'b00, a, b, ph, sb, 1'b0, o);
            checks++; if (o.who != expWho || o.timeout != 0) begin errors++; $display("[TB] FAIL rnd_owner%0d: got %0d timeout=%0d expected %0d", i, o.who, o.timeout, expWho); end
            checks++; if (o.rx !== sb) begin errors++; $display("[TB] FAIL rnd_rx%0d: got %h expected %h cpha=%b", i, o.rx, sb, ph); end
            checks++; if (o.slaveGot !== expTx) begin errors++; $display("[TB] FAIL rnd_mosi%0d: got %h expected %h cpha=%b", i, o.slaveGot, expTx, ph); end
            checks++; if (o.csLowCount != 18 * clkDiv || o.otherCs != 0) begin errors++; $display("[TB] FAIL rnd_cs%0d: got %0d other=%0d expected %0d 0", i, o.csLowCount, o.otherCs, 18 * clkDiv); end
        end
    endtask

    task automatic test_reset_abort;
        obs_t o;
        bit got, sawDone, sawBusy;
        int t0, expWho;
        got = 0; t0 = 0;
        req0 = 1'b1; tx0 = 8'($urandom); cpha = 1'($urandom);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (gnt0) begin got = 1; t0 = cyc; end
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        checks++; if (!got) begin errors++; $display("[TB] FAIL abort_grant: got none expected gnt0"); return; end
        while (cyc < t0 + 9 * clkDiv) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || cs0 !== 1'b0 || sclk !== 1'b0) begin errors++; $display("[TB] FAIL abort_midframe: got busy=%b cs0=%b sclk=%b expected 1 0 0", busy, cs0, sclk); end
        @(posedge clk); #1;
        reset = 1'b1; rrLast = 1'b1;
        @(negedge clk);
        checks++; if (cs0 !== 1'b1 || cs1 !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_state: got cs=%b%b sclk=%b busy=%b expected 11 0 0", cs1, cs0, sclk, busy); end
        sawDone = 0; sawBusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 || done1) sawDone = 1;
            if (busy) sawBusy = 1;
        end
        checks++; if (sawDone || sawBusy) begin errors++; $display("[TB] FAIL abort_resume: got done=%b busy=%b expected 0 0", sawDone, sawBusy); end
        @(posedge clk); #1;
        expWho = modelPick(1'b1, 1'b0);
        applyStimulus(2'b01, 2'b00, 8'hC3, 8'h00, 1'b0, 8'h00, 1'b1, o);
        checks++; if (o.who != expWho || o.rx !== 8'hC3 || o.doneCycle - o.gntCycle != 1 + 18 * clkDiv) begin errors++; $display("[TB] FAIL abort_recover: got owner %0d rx %h lat %0d expected %0d c3 %0d", o.who, o.rx, o.doneCycle - o.gntCycle, expWho, 1 + 18 * clkDiv); end
    endtask

    task automatic test_clkdiv1;
        obs_t o;
        int expWho;
        logic [7:0] pat [2];
        pat[0] = 8'hFF; pat[1] = 8'h00;
        do_reset();
        useOne = 1'b1; clkDiv = 1;
        for (int i = 0; i < 2; i++) begin
            expWho = modelPick(1'b1, 1'b0);
            applyStimulus(2'b01, 2'b00, pat[i], 8'hA5, 1'b0, 8'h00, 1'b1, o);
            checks++; if (o.who != expWho || o.rx !== pat[i]) begin errors++; $display("[TB] FAIL div1_rx%0d: got owner %0d rx %h expected %0d %h", i, o.who, o.rx, expWho, pat[i]); end
            checks++; if (o.doneCycle - o.gntCycle != 19) begin errors++; $display("[TB] FAIL div1_latency%0d: got %0d expected 19", i, o.doneCycle - o.gntCycle); end
            checks++; if (o.rises != 8) begin errors++; $display("[TB] FAIL div1_rises%0d: got %0d expected 8", i, o.rises); end
        end
        repeat (3) begin @(posedge clk); #1; end
        useOne = 1'b0; clkDiv = 2;
    endtask

    initial begin
        useOne = 1'b0; clkDiv = 2; rrLast = 1'b1;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tx0 = 8'h00; tx1 = 8'h00; cpha = 1'b0; miso = 1'b0;
        @(posedge clk); #1;
        $display("[TB] starting spi_master_arbiter bench");
        test_reset();
        test_loopback_cpha0();
        test_cpha1_slave();
        test_arbitration();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2, sclk half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0, req1  input  1 each  transfer requests from requester 0 and requester 1; level, held until the matching gnt.
REQ-005 tx0, tx1  input  8 each  transmit bytes; sampled in the grant cycle.
REQ-006 cpha  input  1  SPI phase for the next frame; sampled in the grant cycle.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-008 done0, done1  output  1 each  one-cycle frame-complete pulse to the owning requester.
REQ-009 rx_data  output  8  byte received on miso; valid with done, held until the next done.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 sclk  output  1  SPI clock, CPOL=0 (idles low).
REQ-012 cs0, cs1  output  1 each  active-low slave selects; cs0 belongs to requester 0, cs1 to requester 1.
REQ-013 mosi  output  1  serial out, MSB first.
REQ-014 miso  input  1  serial in, MSB first.

Function
REQ-015 FSM states: IDLE, SETUP, XFER, HOLD, GAP; a half-period counter counts CLK_DIV cycles in every state except IDLE.
REQ-016 IDLE: if any req is high, grant exactly one requester, pulse its gnt, latch its tx byte, latch cpha and the owner, and move to SETUP next cycle.
REQ-017 Arbitration is round-robin: when both requests are high, grant the requester not served last; the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-018 SETUP: owner cs low, sclk 0, lasts CLK_DIV cycles; for cpha=0, mosi = tx bit7 from SETUP entry.
REQ-019 XFER: 16 half-periods of CLK_DIV cycles; sclk toggles at the start of each, odd edges rising and even edges falling; sclk is low when XFER ends.
REQ-020 cpha=0: sample miso on rising edges; mosi advances to the next bit on falling edges 2..14; mosi is unchanged on edge 16.
REQ-021 cpha=1: mosi takes the next bit on rising edges (bit7 on edge 1); sample miso on falling edges.
REQ-022 HOLD: owner cs stays low, sclk 0, lasts CLK_DIV cycles.
REQ-023 GAP: all cs high, mosi 0; in its first cycle pulse the owner's done and update rx_data; GAP lasts CLK_DIV cycles, then IDLE.
REQ-024 Latency: with grant in cycle T0, done occurs in cycle T0+1+18*CLK_DIV; the next grant comes no earlier than T0+1+19*CLK_DIV.
REQ-025 Requests arriving while busy stay pending and are arbitrated in IDLE.
REQ-026 Changes to tx, cpha or req after grant do not affect the frame in progress.
REQ-027 At most one cs is low at any time; a non-owner cs never goes low.
REQ-028 Re-granting the same requester is allowed when only it requests, even if it was served last.

Reset
REQ-029 While reset=0 at a clk edge: state IDLE; sclk=0; mosi=0; cs0=cs1=1; gnt*, done*=0; busy=0; rx_data=8'h00; last-served pointer=1.
REQ-030 Reset mid-frame aborts immediately: cs high and sclk low next cycle; no done is issued; the frame is not resumed.

Verification
REQ-031 CLK_DIV=2, miso looped to mosi, req0 with tx0=8'hAD, cpha=0 -> gnt0 at T0, cs0 low T0+1..T0+36, eight rising sclk edges, done0 at T0+37, rx_data=8'hAD.
REQ-032 cpha=1, req1 with tx1=8'h69, miso driven by a slave model returning 8'h3C -> mosi bits change on rising edges, done1 pulses, rx_data=8'h3C, cs0 stays high throughout.
REQ-033 req0 and req1 rise in the same cycle after reset -> gnt0 first, then gnt1 as the next grant; with both held, grants alternate 0,1,0,1.
REQ-034 req0 held continuously, req1 low -> back-to-back frames; minimum gap between done0 and the next gnt0 is CLK_DIV cycles.
REQ-035 reset=0 during edge 9 of XFER -> next cycle cs0=cs1=1, sclk=0, busy=0; no done; a new req0 afterwards completes normally.
REQ-036 CLK_DIV=1, tx0=8'hFF and 8'h00 with loopback -> rx_data matches each byte; done0 at T0+19.
